spi_master_param: RTL

Parametrised successor to the fixed RDID-only SPI master: a generic full-duplex SPI master.
- Frame width, SCLK divider and SPI mode (CPOL/CPHA) are configurable.
- Chip select can be held low across frames, so multi-byte commands (RDID + 3 ID bytes, READ + address + data) run as back-to-back frames.
- Sits between system control logic and an SPI flash such as the m25p16 model.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_master_param_if.sv | 25 ++
 rtl/spi_clk_div.sv | 28 ++
 rtl/spi_master_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM state encoding
// and the four SPI mode codes, packed as {cpol, cpha}.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        END   = 3'd4
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_param_if.sv
// Control/status bus between system logic and the SPI master.
// "master" is the controlling side; "slave" is the SPI master block itself.
interface spi_master_param_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cpol;
    logic              cpha;
    logic              hold_cs;
    logic              stop;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, cpol, cpha, hold_cs, stop,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, cpol, cpha, hold_cs, stop,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_clk_div.sv
// Free-running 0..CLK_DIV-1 counter; tick marks the terminal count.
// restart forces the count back to zero so a new state gets a full period.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Count up, wrapping on tick or on an explicit restart.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_param.sv
// Generic full-duplex SPI master: configurable frame width, SCLK divider and
// SPI mode, with chip select optionally held low across back-to-back frames.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_param_if.slave ctrl,
    output logic              SPICLK,
    output logic              SPIMOSI,
    input  logic              SPIMISO,
    output logic              SPICS_N
);
    localparam int EW = $clog2(2 * DATA_W);

    state_t            state;
    logic              cpol_q, cpha_q, hold_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, rx_data_q;
    logic [EW-1:0]     edge_cnt;
    logic              busy_q, done_q, sclk_q, mosi_q, cs_n_q;
    logic              tick, accept, stop_take, restart;
    logic              eff_cpha, sample_edge, last_edge;

    // A frame is accepted only when idle or holding CS; start beats stop.
    assign accept      = ctrl.start && (state == IDLE || state == HOLD);
    assign stop_take   = ctrl.stop && !ctrl.start && (state == HOLD);
    assign restart     = accept || stop_take;
    // From HOLD the mode of the held transaction is reused.
    assign eff_cpha    = (state == IDLE) ? ctrl.cpha : cpha_q;
    // Even edges are leading edges; cpha selects which parity samples.
    assign sample_edge = (edge_cnt[0] == cpha_q);
    assign last_edge   = (edge_cnt == EW'(2 * DATA_W - 1));
    assign rx_next     = sample_edge ? {rx_sr[DATA_W-2:0], SPIMISO} : rx_sr;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Frame FSM with shift registers and registered SPI pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            hold_q    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            edge_cnt  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            // NOTE: done defaults low each cycle so a single assignment below yields a one-cycle pulse.
            done_q <= 1'b0;

            if (accept) begin
                // With cpha=0 the MSB must be on MOSI before the first leading edge.
                tx_sr <= eff_cpha ? ctrl.tx_data : (ctrl.tx_data << 1);
                if (!eff_cpha) begin
                    mosi_q <= ctrl.tx_data[DATA_W-1];
                end
                hold_q   <= ctrl.hold_cs;
                edge_cnt <= '0;
                busy_q   <= 1'b1;
                cs_n_q   <= 1'b0;
                state    <= SETUP;
            end

            case (state)
                IDLE: begin
                    if (ctrl.start) begin
                        cpol_q <= ctrl.cpol;
                        cpha_q <= ctrl.cpha;
                        sclk_q <= ctrl.cpol;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            rx_sr <= rx_next;
                        end else begin
                            mosi_q <= tx_sr[DATA_W-1];
                            tx_sr  <= tx_sr << 1;
                        end
                        if (last_edge) begin
                            done_q    <= 1'b1;
                            rx_data_q <= rx_next;
                            if (hold_q) begin
                                busy_q <= 1'b0;
                                state  <= HOLD;
                            end else begin
                                state  <= END;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (stop_take) begin
                        busy_q <= 1'b1;
                        state  <= END;
                    end
                end
                END: begin
                    if (tick) begin
                        cs_n_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SPICLK       = sclk_q;
    assign SPIMOSI      = mosi_q;
    assign SPICS_N      = cs_n_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.rx_data = rx_data_q;
endmodule
